uart_tx_buf: RTL and testbench

Buffered UART transmitter on the FPGA-to-ESP32/PC serial link. It accepts bytes from fabric logic through a valid/ready write port into an internal FIFO and serialises them on `txd` as 8N1 or 8N2 frames (8E1/8E2 with parity enabled). Baud timing comes from an internal divider running on the system clock, so the block needs no external baud clock. It is the transmit-direction counterpart of the serial receive path in `uart_top`.

---
 rtl/uart_tx_buf.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_buf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// Buffered 8N1/8N2 UART transmitter: valid/ready write port into a circular FIFO, internal baud divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1/8E2).
module uart_tx_buf #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic wr_en;
  logic pop;
  logic div_last;
  logic fifo_empty;

  assign wr_ready   = (count_q != FULL_CNT);
  assign wr_en      = wr_valid && wr_ready;
  assign div_last   = (div_q == DIV_LAST);
  assign fifo_empty = (count_q == '0);

  // txd_d reflects the current state; registering it delays the line by one cycle uniformly.
  always_comb begin
    state_d = state_q;
    div_d   = div_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = 1'b1;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (div_last) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        txd_d = shift_q[bit_q];
        if (div_last) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_d = ^shift_q;
        if (div_last) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        txd_d = 1'b1;
        if (div_last) begin
          div_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array is not reset; the count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign txd        = txd_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: two instances (1 and 2 stop bits) decoded cycle-exactly on txd.
module tb_uart_tx_buf;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CPB     = 4;
  localparam int FRAME_A = (1 + 8 + P + 1) * CPB;
  localparam int FRAME_B = (1 + 8 + P + 2) * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wrDataA = '0, wrDataB = '0;
  logic       wrValidA = 1'b0, wrValidB = 1'b0;
  logic       wrReadyA, wrReadyB, txdA, txdB, busyA, busyB;
  logic [2:0] countA, countB;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  logic [7:0] expA[$];
  logic [7:0] expB[$];
  int startA[$];
  int startB[$];
  int fullSeen = 0;
  int readyBad = 0;
  int maxCount = 0;

  uart_tx_buf #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(1)) dutA (
    .clk(clk), .rst_n(rst_n), .wr_data(wrDataA), .wr_valid(wrValidA), .wr_ready(wrReadyA),
    .txd(txdA), .busy(busyA), .fifo_count(countA));

  uart_tx_buf #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(2)) dutB (
    .clk(clk), .rst_n(rst_n), .wr_data(wrDataB), .wr_valid(wrValidB), .wr_ready(wrReadyB),
    .txd(txdB), .busy(busyB), .fifo_count(countB));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Watches the A write port for correct back-pressure at the FIFO_DEPTH=4 boundary.
  always @(negedge clk) begin
    if (rst_n) begin
      if (countA == 3'd4) fullSeen = 1;
      if (wrReadyA != (countA != 3'd4)) readyBad++;
      if (int'(countA) > maxCount) maxCount = int'(countA);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Offers one byte, holds until accepted, and pushes it into the scoreboard on acceptance.
  task automatic applyStimulus(input int which, input logic [7:0] data, output int acceptCyc);
    logic ok;
    acceptCyc = -1;
    if (which == 0) begin wrDataA = data; wrValidA = 1'b1; end
    else begin wrDataB = data; wrValidB = 1'b1; end
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      ok = (which == 0) ? wrReadyA : wrReadyB;
      @(posedge clk);
      #1;
      if (ok) begin
        acceptCyc = cyc;
        if (which == 0) expA.push_back(data); else expB.push_back(data);
        break;
      end
    end
    if (acceptCyc < 0) checkOutput("write accept timeout", 32'd0, 32'd1);
    wrValidA = 1'b0;
    wrValidB = 1'b0;
  endtask

  task automatic waitDrain(input int which, input int budget);
    logic done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clk);
      if (which == 0) done = !busyA && expA.size() == 0;
      else            done = !busyB && expB.size() == 0;
    end
    checkOutput(which == 0 ? "drain A" : "drain B", 32'(done), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic smp(input int which, output logic v, inout logic ab);
    @(negedge clk);
    v = (which == 0) ? txdA : txdB;
    if (!rst_n) ab = 1'b1;
  endtask

  // Decodes frames cycle by cycle and pops the scoreboard for each completed frame.
  task automatic monitorLoop(input int which, input int stops);
    logic v, v0, ok, ab;
    logic [7:0] b, e;
    logic pb;
    forever begin
      ab = 1'b0;
      smp(which, v, ab);
      if (v == 1'b0 && !ab) begin
        ok = 1'b1;
        pb = 1'b0;
        b  = '0;
        if (which == 0) startA.push_back(cyc); else startB.push_back(cyc);
        for (int k = 0; k < CPB - 1; k++) begin smp(which, v, ab); if (v !== 1'b0) ok = 1'b0; end
        for (int i = 0; i < 8; i++) begin
          smp(which, v0, ab);
          b[i] = v0;
          for (int k = 0; k < CPB - 1; k++) begin smp(which, v, ab); if (v !== v0) ok = 1'b0; end
        end
        for (int i = 0; i < P; i++) begin
          smp(which, v0, ab);
          pb = v0;
          for (int k = 0; k < CPB - 1; k++) begin smp(which, v, ab); if (v !== v0) ok = 1'b0; end
        end
        for (int k = 0; k < stops * CPB; k++) begin smp(which, v, ab); if (v !== 1'b1) ok = 1'b0; end
        if (!ab) begin
          if ((which == 0 && expA.size() == 0) || (which == 1 && expB.size() == 0)) begin
            checkOutput("unexpected frame", {24'd0, b}, 32'hFFFF_FFFF);
          end else begin
            e = (which == 0) ? expA.pop_front() : expB.pop_front();
            checkOutput(which == 0 ? "frame A byte" : "frame B byte", {24'd0, b}, {24'd0, e});
            checkOutput(which == 0 ? "frame A shape" : "frame B shape", 32'(ok), 32'd1);
            if (P == 1) checkOutput("parity bit", 32'(pb), 32'(^e));
          end
        end
      end
    end
  endtask

  initial monitorLoop(0, 1);
  initial monitorLoop(1, 2);

  initial begin
    int c0, c1, fallCyc, lowSeen;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset txd", 32'(txdA), 32'd1);
    checkOutput("reset busy", 32'(busyA), 32'd0);
    checkOutput("reset wr_ready", 32'(wrReadyA), 32'd1);
    checkOutput("reset count", 32'(countA), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single byte: start delay, bit pattern and busy fall time.
    startA.delete();
    applyStimulus(0, 8'h55, c0);
    checkOutput("count after write", 32'(countA), 32'd1);
    fallCyc = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!busyA) begin fallCyc = cyc; break; end
    end
    checkOutput("busy fall cycle", 32'(fallCyc - c0), 32'(1 + FRAME_A));
    waitDrain(0, 200);
    checkOutput("start delay", 32'(startA.size() > 0 ? startA[0] - c0 : -1), 32'd2);

    // Back-to-back frames with no idle gap.
    @(posedge clk); #1;
    startA.delete();
    applyStimulus(0, 8'h00, c0);
    applyStimulus(0, 8'hFF, c1);
    waitDrain(0, 300);
    checkOutput("back-to-back gap", 32'(startA.size() > 1 ? startA[1] - startA[0] : -1), 32'(FRAME_A));

    // Parity-relevant bytes (also plain frames when parity is disabled).
    @(posedge clk); #1;
    applyStimulus(0, 8'h07, c0);
    applyStimulus(0, 8'h03, c1);
    waitDrain(0, 300);

    // Full FIFO: six bytes held against a depth-4 buffer.
    @(posedge clk); #1;
    fullSeen = 0; readyBad = 0; maxCount = 0;
    for (int i = 1; i <= 6; i++) applyStimulus(0, 8'(i), c0);
    waitDrain(0, 800);
    checkOutput("fifo reached full", 32'(fullSeen), 32'd1);
    checkOutput("max count", 32'(maxCount), 32'd4);
    checkOutput("wr_ready vs count", 32'(readyBad), 32'd0);

    // Two stop bits, followed directly by a queued frame.
    @(posedge clk); #1;
    startB.delete();
    applyStimulus(1, 8'h81, c0);
    applyStimulus(1, 8'h42, c1);
    waitDrain(1, 300);
    checkOutput("2-stop gap", 32'(startB.size() > 1 ? startB[1] - startB[0] : -1), 32'(FRAME_B));

    // Reset in the middle of the data bits.
    @(posedge clk); #1;
    applyStimulus(0, 8'hA5, c0);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("busy before reset", 32'(busyA), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset mid txd", 32'(txdA), 32'd1);
    checkOutput("reset mid count", 32'(countA), 32'd0);
    checkOutput("reset mid busy", 32'(busyA), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    expA.delete();
    rst_n = 1'b1;
    lowSeen = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!txdA || busyA) lowSeen++;
    end
    checkOutput("idle after reset", 32'(lowSeen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
